// File: rtl/ifft_butterfly_dit_if.sv
// Butterfly operand/result bus: input beat (A, B, W) with valid/ready, output beat (X, Y) with valid/ready.
// master drives operands and out_ready; slave is the butterfly.
interface ifft_butterfly_dit_if #(
  parameter int DATA_W = 16,
  parameter int TW_W   = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] a_r;
  logic signed [DATA_W-1:0] a_i;
  logic signed [DATA_W-1:0] b_r;
  logic signed [DATA_W-1:0] b_i;
  logic signed [TW_W-1:0]   w_r;
  logic signed [TW_W-1:0]   w_i;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] x_r;
  logic signed [DATA_W-1:0] x_i;
  logic signed [DATA_W-1:0] y_r;
  logic signed [DATA_W-1:0] y_i;
  logic                     out_sat;
  logic [15:0]              sat_count;

  modport master (
    output in_valid, a_r, a_i, b_r, b_i, w_r, w_i, out_ready,
    input  in_ready, out_valid, x_r, x_i, y_r, y_i, out_sat, sat_count
  );

  modport slave (
    input  in_valid, a_r, a_i, b_r, b_i, w_r, w_i, out_ready,
    output in_ready, out_valid, x_r, x_i, y_r, y_i, out_sat, sat_count
  );
endinterface

// File: rtl/ifft_butterfly_dit.sv
// Radix-2 DIT IFFT butterfly X/Y = A +/- B*conj(W), 3 register stages, stalls whole pipe when output is held.
// IFFT_SCALE_EN: halve sx/sy before saturation (per-stage 1/2 scaling).
module ifft_butterfly_dit #(
  parameter int DATA_W = 16,
  parameter int TW_W   = 16,
  parameter int R      = 14
) (
  input logic              clk,
  input logic              reset,
  ifft_butterfly_dit_if.slave bus
);
  localparam int PW = DATA_W + TW_W + 1;
  localparam int SW = DATA_W + 2;

  logic w_adv;

  logic r_v1;
  logic r_v2;
  logic r_v3;

  logic signed [DATA_W-1:0] r_a1_r;
  logic signed [DATA_W-1:0] r_a1_i;
  logic signed [PW-1:0]     r_p_r;
  logic signed [PW-1:0]     r_p_i;
  logic signed [DATA_W-1:0] r_a2_r;
  logic signed [DATA_W-1:0] r_a2_i;
  logic signed [SW-1:0]     r_q_r;
  logic signed [SW-1:0]     r_q_i;
  logic signed [DATA_W-1:0] r_x_r;
  logic signed [DATA_W-1:0] r_x_i;
  logic signed [DATA_W-1:0] r_y_r;
  logic signed [DATA_W-1:0] r_y_i;
  logic                     r_sat;
  logic [15:0]              r_cnt;

  logic signed [PW-1:0] w_b_r;
  logic signed [PW-1:0] w_b_i;
  logic signed [PW-1:0] w_w_r;
  logic signed [PW-1:0] w_w_i;
  logic signed [PW-1:0] w_p_r;
  logic signed [PW-1:0] w_p_i;

  logic signed [SW-1:0] w_sx_r;
  logic signed [SW-1:0] w_sx_i;
  logic signed [SW-1:0] w_sy_r;
  logic signed [SW-1:0] w_sy_i;
  logic signed [SW-1:0] w_tx_r;
  logic signed [SW-1:0] w_tx_i;
  logic signed [SW-1:0] w_ty_r;
  logic signed [SW-1:0] w_ty_i;
  logic [DATA_W:0]      w_cx_r;
  logic [DATA_W:0]      w_cx_i;
  logic [DATA_W:0]      w_cy_r;
  logic [DATA_W:0]      w_cy_i;

  // Returns {clipped, value}; clipped when the guard bits disagree with the result sign bit.
  function automatic logic [DATA_W:0] sat_fn(input logic signed [SW-1:0] v);
    logic [SW-DATA_W:0] top;
    top = v[SW-1:DATA_W-1];
    if (top == '0 || top == '1) begin
      sat_fn = {1'b0, v[DATA_W-1:0]};
    end else begin
      sat_fn = {1'b1, v[SW-1], {(DATA_W-1){~v[SW-1]}}};
    end
  endfunction

  assign w_adv = ~r_v3 | bus.out_ready;

  assign w_b_r = {{(PW-DATA_W){bus.b_r[DATA_W-1]}}, bus.b_r};
  assign w_b_i = {{(PW-DATA_W){bus.b_i[DATA_W-1]}}, bus.b_i};
  assign w_w_r = {{(PW-TW_W){bus.w_r[TW_W-1]}}, bus.w_r};
  assign w_w_i = {{(PW-TW_W){bus.w_i[TW_W-1]}}, bus.w_i};

  // B * conj(W): the conjugate flips the sign of the w_i cross terms.
  assign w_p_r = w_b_r * w_w_r + w_b_i * w_w_i;
  assign w_p_i = w_b_i * w_w_r - w_b_r * w_w_i;

  assign w_sx_r = {{2{r_a2_r[DATA_W-1]}}, r_a2_r} + r_q_r;
  assign w_sx_i = {{2{r_a2_i[DATA_W-1]}}, r_a2_i} + r_q_i;
  assign w_sy_r = {{2{r_a2_r[DATA_W-1]}}, r_a2_r} - r_q_r;
  assign w_sy_i = {{2{r_a2_i[DATA_W-1]}}, r_a2_i} - r_q_i;

`ifdef IFFT_SCALE_EN
  assign w_tx_r = w_sx_r >>> 1;
  assign w_tx_i = w_sx_i >>> 1;
  assign w_ty_r = w_sy_r >>> 1;
  assign w_ty_i = w_sy_i >>> 1;
`else
  assign w_tx_r = w_sx_r;
  assign w_tx_i = w_sx_i;
  assign w_ty_r = w_sy_r;
  assign w_ty_i = w_sy_i;
`endif

  assign w_cx_r = sat_fn(w_tx_r);
  assign w_cx_i = sat_fn(w_tx_i);
  assign w_cy_r = sat_fn(w_ty_r);
  assign w_cy_i = sat_fn(w_ty_i);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_v3   <= 1'b0;
      r_a1_r <= '0;
      r_a1_i <= '0;
      r_p_r  <= '0;
      r_p_i  <= '0;
      r_a2_r <= '0;
      r_a2_i <= '0;
      r_q_r  <= '0;
      r_q_i  <= '0;
      r_x_r  <= '0;
      r_x_i  <= '0;
      r_y_r  <= '0;
      r_y_i  <= '0;
      r_sat  <= 1'b0;
    end else if (w_adv) begin
      r_v1   <= bus.in_valid;
      r_a1_r <= bus.a_r;
      r_a1_i <= bus.a_i;
      r_p_r  <= w_p_r;
      r_p_i  <= w_p_i;
      r_v2   <= r_v1;
      r_a2_r <= r_a1_r;
      r_a2_i <= r_a1_i;
      r_q_r  <= SW'(r_p_r >>> R);
      r_q_i  <= SW'(r_p_i >>> R);
      r_v3   <= r_v2;
      r_x_r  <= w_cx_r[DATA_W-1:0];
      r_x_i  <= w_cx_i[DATA_W-1:0];
      r_y_r  <= w_cy_r[DATA_W-1:0];
      r_y_i  <= w_cy_i[DATA_W-1:0];
      r_sat  <= w_cx_r[DATA_W] | w_cx_i[DATA_W] | w_cy_r[DATA_W] | w_cy_i[DATA_W];
    end
  end

  // Counts only beats actually handed downstream, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_v3 && bus.out_ready && r_sat && (r_cnt != 16'hFFFF)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign bus.in_ready  = w_adv;
  assign bus.out_valid = r_v3;
  assign bus.x_r       = r_x_r;
  assign bus.x_i       = r_x_i;
  assign bus.y_r       = r_y_r;
  assign bus.y_i       = r_y_i;
  assign bus.out_sat   = r_sat;
  assign bus.sat_count = r_cnt;
endmodule
